mux5_rr_scheduler: RTL and testbench

- Round-robin scheduler for the shared 3-bit, 5-input multiplexer datapath.
- Five requesters each present a 3-bit word and a request line.
- The block grants the datapath to one requester at a time for a fixed dwell of DWELL cycles.
- It drives the select code using the mux encoding S=000→u, 001→v, 010→w, 011→x, 100→y, and reports the routed word with a valid flag and a per-requester completion pulse.

---
 rtl/mux5_rr_scheduler_if.sv | 31 +++
 rtl/mux5_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_mux5_rr_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux5_rr_scheduler_if.sv
// Bundle of requester-side and datapath-side signals for the 5-input
// round-robin mux scheduler.
interface mux5_rr_scheduler_if;
    logic [4:0]  req;
    logic [14:0] data_in;
    logic [2:0]  sel;
    logic [4:0]  grant;
    logic [2:0]  data_out;
    logic        valid;
    logic [4:0]  done;

    modport master (
        output req,
        output data_in,
        input  sel,
        input  grant,
        input  data_out,
        input  valid,
        input  done
    );

    modport slave (
        input  req,
        input  data_in,
        output sel,
        output grant,
        output data_out,
        output valid,
        output done
    );
endinterface

// File: rtl/mux5_rr_scheduler.sv
// Round-robin scheduler granting a shared 3-bit, 5-input mux to one
// requester at a time for a fixed dwell of DWELL cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; arbitrates on any request, sel keeps its last value
// HOLD  | requester sel owns the mux; cnt counts down the dwell
module mux5_rr_scheduler #(
    parameter int DWELL = 4,
    parameter int CW    = 4
) (
    input logic                 clock,
    input logic                 resetn,
    mux5_rr_scheduler_if.slave  bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n;
    logic [2:0]    sel_q, sel_n;
    logic [4:0]    grant_q, grant_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    done_c;
    logic [2:0]    data_out_c;
    logic [2:0]    base;
    logic [2:0]    win_idx;
    logic [3:0]    arb_sum;
    logic          win_any;
    logic          drop;
    logic          expire;

    function automatic logic [2:0] inc5(input logic [2:0] i);
        return (i >= 3'd4) ? 3'd0 : i + 3'd1;
    endfunction

    function automatic logic [4:0] onehot5(input logic [2:0] i);
        return 5'b00001 << i;
    endfunction

    // On release from HOLD the pointer moves past g in the same edge, so
    // the search must already start from g+1 to avoid an idle bubble.
    always_comb begin
        base    = (state == HOLD) ? inc5(sel_q) : ptr;
        win_any = |bus.req;
        win_idx = base;
        arb_sum = 4'd0;
        for (int k = 4; k >= 0; k--) begin
            arb_sum = {1'b0, base} + 4'(k);
            if (arb_sum >= 4'd5)
                arb_sum = arb_sum - 4'd5;
            if (bus.req[arb_sum[2:0]])
                win_idx = arb_sum[2:0];
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel_q;
        grant_n = grant_q;
        cnt_n   = cnt;
        done_c  = 5'b00000;
        drop    = 1'b0;
        expire  = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_n = HOLD;
                    grant_n = onehot5(win_idx);
                    sel_n   = win_idx;
                    cnt_n   = DWELL_M1;
                end
            end
            HOLD: begin
                // A dropped request wins over terminal count: no done pulse.
                drop   = !bus.req[sel_q];
                expire = !drop && (cnt == '0);
                if (expire)
                    done_c = grant_q;
                if (drop || expire) begin
                    ptr_n = inc5(sel_q);
                    if (win_any) begin
                        grant_n = onehot5(win_idx);
                        sel_n   = win_idx;
                        cnt_n   = DWELL_M1;
                    end else begin
                        state_n = IDLE;
                        grant_n = 5'b00000;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 5'b00000;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            sel_q   <= 3'd0;
            grant_q <= 5'b00000;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            sel_q   <= sel_n;
            grant_q <= grant_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        data_out_c = 3'b000;
        if (|grant_q) begin
            case (sel_q)
                3'd0:    data_out_c = bus.data_in[2:0];
                3'd1:    data_out_c = bus.data_in[5:3];
                3'd2:    data_out_c = bus.data_in[8:6];
                3'd3:    data_out_c = bus.data_in[11:9];
                3'd4:    data_out_c = bus.data_in[14:12];
                default: data_out_c = 3'b000;
            endcase
        end
    end

    assign bus.sel      = sel_q;
    assign bus.grant    = grant_q;
    assign bus.valid    = |grant_q;
    assign bus.data_out = data_out_c;
    assign bus.done     = done_c;

endmodule

// File: tb/tb_mux5_rr_scheduler.sv
// Directed self-checking bench for mux5_rr_scheduler: one DWELL=4 instance
// for the main scenarios and one DWELL=1 instance for single-cycle grants.
module tb_mux5_rr_scheduler;

    logic clock;
    logic resetn;
    int   pass_cnt;
    int   total_cnt;

    mux5_rr_scheduler_if bus  ();
    mux5_rr_scheduler_if bus1 ();

    mux5_rr_scheduler #(.DWELL(4), .CW(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    mux5_rr_scheduler #(.DWELL(1), .CW(4)) dut1 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus1.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.req  = 5'b00000;
        bus1.req = 5'b00000;
        resetn   = 1'b0;
        tick();
        resetn   = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.data_in = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        bus.req     = 5'b00000;
        resetn      = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        total_cnt++;
        if ({bus.grant, bus.sel, bus.valid, bus.data_out, bus.done} !== 17'd0)
            $display("FAIL reset_init grant=%b sel=%b valid=%b data_out=%b done=%b exp all zero",
                     bus.grant, bus.sel, bus.valid, bus.data_out, bus.done);
        else pass_cnt++;

        tick();
        resetn  = 1'b1;
        bus.req = 5'b00100;
        tick();
        total_cnt++;
        if (bus.grant !== 5'b00100)
            $display("FAIL reset_pre_grant grant=%b exp 00100", bus.grant);
        else pass_cnt++;

        tick();
        #2;
        resetn = 1'b0;
        #1;
        total_cnt++;
        if ({bus.grant, bus.sel, bus.valid, bus.data_out, bus.done} !== 17'd0)
            $display("FAIL reset_async grant=%b sel=%b valid=%b data_out=%b done=%b exp all zero",
                     bus.grant, bus.sel, bus.valid, bus.data_out, bus.done);
        else pass_cnt++;

        bus.req = 5'b00000;
        tick();
        resetn = 1'b1;
        tick();
        tick();
        tick();
        total_cnt++;
        if (bus.grant !== 5'b00000 || bus.valid !== 1'b0 || bus.data_out !== 3'b000)
            $display("FAIL reset_stay_idle grant=%b valid=%b data_out=%b exp 00000/0/000",
                     bus.grant, bus.valid, bus.data_out);
        else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        bus.data_in = {3'd6, 3'd7, 3'b101, 3'd2, 3'd1};
        bus.req     = 5'b00100;
        for (int c = 0; c < 4; c++) begin
            tick();
            total_cnt++;
            if (bus.grant !== 5'b00100 || bus.sel !== 3'b010 || bus.valid !== 1'b1)
                $display("FAIL single_grant c=%0d grant=%b sel=%b valid=%b exp 00100/010/1",
                         c, bus.grant, bus.sel, bus.valid);
            else pass_cnt++;
            total_cnt++;
            if (bus.data_out !== 3'b101)
                $display("FAIL single_data c=%0d data_out=%b exp 101", c, bus.data_out);
            else pass_cnt++;
            total_cnt++;
            if (bus.done !== ((c == 3) ? 5'b00100 : 5'b00000))
                $display("FAIL single_done c=%0d done=%b exp %b", c, bus.done,
                         (c == 3) ? 5'b00100 : 5'b00000);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (bus.grant !== 5'b00100 || bus.done !== 5'b00000)
            $display("FAIL single_regrant grant=%b done=%b exp 00100/00000", bus.grant, bus.done);
        else pass_cnt++;
        bus.req = 5'b00000;
        tick();
        total_cnt++;
        if (bus.grant !== 5'b00000 || bus.valid !== 1'b0)
            $display("FAIL single_release grant=%b valid=%b exp 00000/0", bus.grant, bus.valid);
        else pass_cnt++;
    endtask

    task automatic test_rotate();
        logic [4:0] exp_grant;
        logic [4:0] exp_done;
        logic [2:0] g;
        do_reset();
        bus.data_in = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        bus.req     = 5'b11111;
        for (int n = 0; n < 6; n++) begin
            g = 3'(n % 5);
            exp_grant = 5'b00001 << g;
            for (int c = 0; c < 4; c++) begin
                tick();
                exp_done = (c == 3) ? exp_grant : 5'b00000;
                total_cnt++;
                if (bus.grant !== exp_grant || bus.sel !== g)
                    $display("FAIL rotate_grant n=%0d c=%0d grant=%b sel=%b exp %b/%b",
                             n, c, bus.grant, bus.sel, exp_grant, g);
                else pass_cnt++;
                total_cnt++;
                if (bus.data_out !== g + 3'd1)
                    $display("FAIL rotate_data n=%0d c=%0d data_out=%b exp %b",
                             n, c, bus.data_out, g + 3'd1);
                else pass_cnt++;
                total_cnt++;
                if (bus.done !== exp_done)
                    $display("FAIL rotate_done n=%0d c=%0d done=%b exp %b",
                             n, c, bus.done, exp_done);
                else pass_cnt++;
            end
        end
        bus.req = 5'b00000;
        tick();
    endtask

    task automatic test_early_drop();
        do_reset();
        bus.data_in = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        bus.req     = 5'b00011;
        tick();
        total_cnt++;
        if (bus.grant !== 5'b00001 || bus.sel !== 3'd0)
            $display("FAIL drop_first grant=%b sel=%b exp 00001/000", bus.grant, bus.sel);
        else pass_cnt++;
        tick();
        bus.req = 5'b00010;
        #1;
        total_cnt++;
        if (bus.done !== 5'b00000)
            $display("FAIL drop_no_done done=%b exp 00000", bus.done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.grant !== 5'b00010 || bus.sel !== 3'd1 || bus.done !== 5'b00000)
            $display("FAIL drop_next grant=%b sel=%b done=%b exp 00010/001/00000",
                     bus.grant, bus.sel, bus.done);
        else pass_cnt++;
        tick();
        tick();
        tick();
        total_cnt++;
        if (bus.done !== 5'b00010)
            $display("FAIL drop_tc_done done=%b exp 00010", bus.done);
        else pass_cnt++;
        bus.req = 5'b00000;
        #1;
        total_cnt++;
        if (bus.done !== 5'b00000)
            $display("FAIL drop_precedence done=%b exp 00000", bus.done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.grant !== 5'b00000 || bus.valid !== 1'b0 || bus.data_out !== 3'b000 || bus.sel !== 3'd1)
            $display("FAIL drop_idle grant=%b valid=%b data_out=%b sel=%b exp 00000/0/000/001",
                     bus.grant, bus.valid, bus.data_out, bus.sel);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.data_in = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        bus.req     = 5'b01000;
        tick();
        total_cnt++;
        if (bus.grant !== 5'b01000 || bus.sel !== 3'd3)
            $display("FAIL wrap_g3 grant=%b sel=%b exp 01000/011", bus.grant, bus.sel);
        else pass_cnt++;
        tick();
        tick();
        tick();
        bus.req = 5'b11001;
        #1;
        total_cnt++;
        if (bus.done !== 5'b01000)
            $display("FAIL wrap_g3_done done=%b exp 01000", bus.done);
        else pass_cnt++;
        tick();
        bus.req = 5'b10001;
        total_cnt++;
        if (bus.grant !== 5'b10000 || bus.sel !== 3'b100 || bus.data_out !== 3'd5)
            $display("FAIL wrap_g4 grant=%b sel=%b data_out=%b exp 10000/100/101",
                     bus.grant, bus.sel, bus.data_out);
        else pass_cnt++;
        tick();
        tick();
        tick();
        total_cnt++;
        if (bus.done !== 5'b10000)
            $display("FAIL wrap_g4_done done=%b exp 10000", bus.done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.grant !== 5'b00001 || bus.sel !== 3'b000 || bus.data_out !== 3'd1)
            $display("FAIL wrap_g0 grant=%b sel=%b data_out=%b exp 00001/000/001",
                     bus.grant, bus.sel, bus.data_out);
        else pass_cnt++;
        bus.req = 5'b00000;
        tick();
    endtask

    task automatic test_dwell1();
        logic [4:0] exp_grant;
        logic [2:0] exp_data;
        do_reset();
        bus1.data_in = {3'd0, 3'b011, 3'd0, 3'b110, 3'd0};
        bus1.req     = 5'b01010;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_grant = (c % 2 == 0) ? 5'b00010 : 5'b01000;
            exp_data  = (c % 2 == 0) ? 3'b110 : 3'b011;
            total_cnt++;
            if (bus1.grant !== exp_grant || bus1.done !== exp_grant)
                $display("FAIL dwell1_grant c=%0d grant=%b done=%b exp %b/%b",
                         c, bus1.grant, bus1.done, exp_grant, exp_grant);
            else pass_cnt++;
            total_cnt++;
            if (bus1.data_out !== exp_data)
                $display("FAIL dwell1_data c=%0d data_out=%b exp %b", c, bus1.data_out, exp_data);
            else pass_cnt++;
        end
        bus1.req = 5'b00000;
        tick();
        total_cnt++;
        if (bus1.grant !== 5'b00000 || bus1.done !== 5'b00000)
            $display("FAIL dwell1_idle grant=%b done=%b exp 00000/00000", bus1.grant, bus1.done);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        bus.req      = 5'b00000;
        bus.data_in  = 15'd0;
        bus1.req     = 5'b00000;
        bus1.data_in = 15'd0;
        test_reset();
        test_single();
        test_rotate();
        test_early_drop();
        test_wrap();
        test_dwell1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
